uart_boot_loader: RTL and testbench



---
 rtl/boot_pkg.sv | 23 ++
 rtl/uart_rx_byte.sv | 101 ++++++++++
 rtl/uart_boot_loader.sv | 208 ++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and constants for the UART boot loader
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHK,
        ST_DONE
    } boot_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         LEN_W             = 16;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - UART 8N1 byte receiver with RX synchroniser and start-bit qualification
module uart_rx_byte
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // A line already high again at mid start bit is a glitch, not a frame.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_valid = valid_q;
    assign rx_data  = shift_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - framed UART program loader driving the instruction memory write port
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int         CLKS_PER_BIT   = 434,
    parameter int         IMEM_WORDS     = 256,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 2000000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        RX,
    output logic        imem_WE,
    output logic [31:0] imem_A,
    output logic [31:0] imem_WD,
    output logic        cpu_stall,
    output logic        prog_mode,
    output logic        cpu_restart,
    output logic        load_ok,
    output logic        load_err
);

    localparam int               WIDX_W   = $clog2(IMEM_WORDS) + 1;
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(IMEM_WORDS);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (CLK),
        .reset   (reset),
        .rx      (RX),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_ferr (rx_ferr)
    );

    boot_state_e       state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [WIDX_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        chk_q, chk_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              imem_we_q, imem_we_d;
    logic [31:0]       imem_a_q, imem_a_d;
    logic [31:0]       imem_wd_q, imem_wd_d;
    logic              prog_q, prog_d;
    logic              restart_q, restart_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;

    logic              fail;
    logic [LEN_W-1:0]  len_full;
    logic [31:0]       word_next;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        chk_d      = chk_q;
        tmo_d      = tmo_q;
        imem_we_d  = 1'b0;
        imem_a_d   = imem_a_q;
        imem_wd_d  = imem_wd_q;
        prog_d     = prog_q;
        restart_d  = 1'b0;
        ok_d       = ok_q;
        err_d      = err_q;
        fail       = 1'b0;
        len_full   = {rx_data, len_q[7:0]};
        word_next  = word_q;
        word_next[{byte_idx_q, 3'b000} +: 8] = rx_data;

        if (state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK}) begin
            if (rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                fail = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
        if (state_q != ST_IDLE && rx_ferr) begin
            fail = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d    = ST_LEN_LO;
                    prog_d     = 1'b1;
                    ok_d       = 1'b0;
                    err_d      = 1'b0;
                    len_d      = '0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    word_d     = '0;
                    chk_d      = '0;
                    tmo_d      = '0;
                end
            end
            ST_LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid) begin
                    len_d = len_full;
                    if (len_full == '0 || len_full > LEN_MAX) begin
                        fail = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    word_d     = word_next;
                    chk_d      = chk_q + rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d  = 1'b1;
                        imem_a_d   = 32'({word_idx_q, 2'b00});
                        imem_wd_d  = word_next;
                        word_idx_d = word_idx_q + WIDX_W'(1);
                        if (LEN_W'(word_idx_q) + LEN_W'(1) == len_q) begin
                            state_d = ST_CHK;
                        end
                    end
                end
            end
            ST_CHK: begin
                if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        state_d   = ST_DONE;
                        ok_d      = 1'b1;
                        prog_d    = 1'b0;
                        restart_d = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // prog_mode is left set: memory may be partially overwritten, so the CPU stays held.
        if (fail) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            chk_q      <= '0;
            tmo_q      <= '0;
            imem_we_q  <= 1'b0;
            imem_a_q   <= '0;
            imem_wd_q  <= '0;
            prog_q     <= 1'b0;
            restart_q  <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            chk_q      <= chk_d;
            tmo_q      <= tmo_d;
            imem_we_q  <= imem_we_d;
            imem_a_q   <= imem_a_d;
            imem_wd_q  <= imem_wd_d;
            prog_q     <= prog_d;
            restart_q  <= restart_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    assign imem_WE     = imem_we_q;
    assign imem_A      = imem_a_q;
    assign imem_WD     = imem_wd_q;
    assign prog_mode   = prog_q;
    assign cpu_stall   = prog_q;
    assign cpu_restart = restart_q;
    assign load_ok     = ok_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - scoreboard bench for uart_boot_loader with a frame-level reference model
module tb_uart_boot_loader;

    localparam int CPB = 8;
    localparam int TMO = 500;
    localparam int IW  = 256;

    localparam logic [1:0] EV_WR  = 2'd0;
    localparam logic [1:0] EV_OK  = 2'd1;
    localparam logic [1:0] EV_ERR = 2'd2;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        RX = 1'b1;
    logic        imem_WE;
    logic [31:0] imem_A;
    logic [31:0] imem_WD;
    logic        cpu_stall;
    logic        prog_mode;
    logic        cpu_restart;
    logic        load_ok;
    logic        load_err;

    always #5 CLK = ~CLK;

    uart_boot_loader #(
        .CLKS_PER_BIT  (CPB),
        .IMEM_WORDS    (IW),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .RX         (RX),
        .imem_WE    (imem_WE),
        .imem_A     (imem_A),
        .imem_WD    (imem_WD),
        .cpu_stall  (cpu_stall),
        .prog_mode  (prog_mode),
        .cpu_restart(cpu_restart),
        .load_ok    (load_ok),
        .load_err   (load_err)
    );

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  rx_bytes = 0;
    logic err_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_ev(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endfunction

    // Frame-level model: the events a loader must produce for the bytes actually delivered.
    function automatic void model(input bq_t fr, input bit abnormal);
        int n;
        logic [7:0] sum;
        logic [31:0] w;
        if (fr.size() == 0 || fr[0] != 8'hA5) return;
        if (fr.size() < 3) begin
            if (abnormal) push_ev(EV_ERR, 0, 0);
            return;
        end
        n = int'(fr[1]) + 256 * int'(fr[2]);
        if (n == 0 || n > IW) begin
            push_ev(EV_ERR, 0, 0);
            return;
        end
        sum = 8'd0;
        for (int i = 0; i < n; i++) begin
            if (fr.size() < 3 + 4 * i + 4) begin
                if (abnormal) push_ev(EV_ERR, 0, 0);
                return;
            end
            w = {fr[3+4*i+3], fr[3+4*i+2], fr[3+4*i+1], fr[3+4*i]};
            sum = sum + fr[3+4*i] + fr[3+4*i+1] + fr[3+4*i+2] + fr[3+4*i+3];
            push_ev(EV_WR, 32'(4 * i), w);
        end
        if (fr.size() > 3 + 4 * n) push_ev((fr[3+4*n] == sum) ? EV_OK : EV_ERR, 0, 0);
        else if (abnormal) push_ev(EV_ERR, 0, 0);
    endfunction

    function automatic bq_t build(input int n, input bit bad, input bit force_a5);
        bq_t f;
        logic [7:0] s;
        logic [7:0] b;
        f = {};
        s = 8'd0;
        f.push_back(8'hA5);
        f.push_back(n[7:0]);
        f.push_back(n[15:8]);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            if (force_a5 && i == 1) b = 8'hA5;
            f.push_back(b);
            s = s + b;
        end
        f.push_back(bad ? s + 8'd1 : s);
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RX = stop;
        repeat (CPB) @(negedge CLK);
        RX = 1'b1;
        if (!stop) repeat (CPB) @(negedge CLK);
    endtask

    task automatic drain(input string name, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge CLK);
            c++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (20) @(negedge CLK);
    endtask

    task automatic run_frame(input string name, input bq_t f, input int ferr_at, input bit abnormal, input int budget);
        bq_t seen;
        seen = {};
        for (int i = 0; i < f.size(); i++) begin
            if (i == ferr_at) break;
            seen.push_back(f[i]);
        end
        model(seen, abnormal || ferr_at >= 0);
        for (int i = 0; i < seen.size(); i++) send_byte(seen[i], 1'b1);
        if (ferr_at >= 0) send_byte(f[ferr_at], 1'b0);
        drain(name, budget);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_WE"}, 32'(imem_WE), 32'd0);
        check({tag, "_imem_A"}, imem_A, 32'd0);
        check({tag, "_imem_WD"}, imem_WD, 32'd0);
        check({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd0);
        check({tag, "_prog_mode"}, 32'(prog_mode), 32'd0);
        check({tag, "_cpu_restart"}, 32'(cpu_restart), 32'd0);
        check({tag, "_load_ok"}, 32'(load_ok), 32'd0);
        check({tag, "_load_err"}, 32'(load_err), 32'd0);
    endtask

    always @(negedge CLK) begin
        if (dut.u_rx.rx_valid) rx_bytes++;
    end

    // Monitor: every observable DUT event must match the head of the expectation queue.
    always @(negedge CLK) begin
        ev_t e;
        if (!reset) begin
            if (imem_WE) begin
                check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("write_kind", 32'(e.kind), 32'(EV_WR));
                    check("imem_A", imem_A, e.a);
                    check("imem_WD", imem_WD, e.d);
                end
            end
            if (cpu_restart) begin
                check("ok_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("ok_kind", 32'(e.kind), 32'(EV_OK));
                    check("ok_load_ok", 32'(load_ok), 32'd1);
                    check("ok_load_err", 32'(load_err), 32'd0);
                    check("ok_prog_mode", 32'(prog_mode), 32'd0);
                    check("ok_cpu_stall", 32'(cpu_stall), 32'd0);
                end
            end
            if (load_err && !err_prev) begin
                check("err_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("err_kind", 32'(e.kind), 32'(EV_ERR));
                    check("err_prog_mode", 32'(prog_mode), 32'd1);
                    check("err_cpu_stall", 32'(cpu_stall), 32'd1);
                    check("err_cpu_restart", 32'(cpu_restart), 32'd0);
                    check("err_load_ok", 32'(load_ok), 32'd0);
                end
            end
        end
        err_prev = load_err;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f;
        bq_t part;
        int  base;

        repeat (5) @(negedge CLK);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (10) @(negedge CLK);

        f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        run_frame("good_2word", f, -1, 1'b0, 100);
        check("good_2word_load_ok", 32'(load_ok), 32'd1);

        f[11] = 8'hB7;
        run_frame("bad_chk", f, -1, 1'b0, 100);
        check("bad_chk_prog_held", 32'(prog_mode), 32'd1);

        run_frame("recover", build(2, 1'b0, 1'b0), -1, 1'b0, 100);
        check("recover_err_cleared", 32'(load_err), 32'd0);

        run_frame("len_zero", '{8'hA5, 8'h00, 8'h00}, -1, 1'b0, 100);
        run_frame("len_257", '{8'hA5, 8'h01, 8'h01}, -1, 1'b0, 100);

        run_frame("len_256", build(IW, 1'b0, 1'b0), -1, 1'b0, 100);
        check("len_256_last_addr", imem_A, 32'h0000_03FC);

        run_frame("ferr_data", build(2, 1'b0, 1'b0), 8, 1'b1, 100);
        run_frame("timeout", '{8'hA5, 8'h02, 8'h00}, -1, 1'b1, TMO + 300);

        run_frame("a5_as_data", build(2, 1'b0, 1'b1), -1, 1'b0, 100);

        base = rx_bytes;
        RX = 1'b0;
        repeat (2) @(negedge CLK);
        RX = 1'b1;
        repeat (40) @(negedge CLK);
        check("glitch_no_byte", 32'(rx_bytes - base), 32'd0);
        send_byte(8'h55, 1'b1);
        repeat (20) @(negedge CLK);
        check("noise_one_byte", 32'(rx_bytes - base), 32'd1);
        check("noise_ignored_prog", 32'(prog_mode), 32'd0);
        check("noise_ignored_ok", 32'(load_ok), 32'd1);

        for (int k = 0; k < 2; k++) begin
            run_frame("random", build($urandom_range(1, 2), 1'($urandom_range(0, 1)), 1'b0), -1, 1'b0, 100);
        end

        f = build(2, 1'b0, 1'b0);
        part = {};
        for (int i = 0; i < 8; i++) part.push_back(f[i]);
        run_frame("pre_reset", part, -1, 1'b0, 100);
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        check_reset_outputs("midreset");
        reset = 1'b0;
        for (int i = 8; i < 11; i++) send_byte((f[i] == 8'hA5) ? 8'h11 : f[i], 1'b1);
        repeat (100) @(negedge CLK);
        check("post_reset_prog", 32'(prog_mode), 32'd0);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
